// File: rtl/hs_utmi_pkg.sv
// Shared types and constants for the HS bit-stuffing transmitter.
// Holds the FSM state encoding, the default stuff run length and the legal word widths.
package hs_utmi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STUFF = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int STUFF_RUN_DEFAULT = 6;
  localparam int STUFF_RUN_MIN     = 2;
  localparam int STUFF_RUN_MAX     = 15;

  localparam int DATA_W_NARROW = 8;
  localparam int DATA_W_WIDE   = 16;

  function automatic bit data_w_legal(input int w);
    return (w == DATA_W_NARROW) || (w == DATA_W_WIDE);
  endfunction

  function automatic bit stuff_run_legal(input int r);
    return (r >= STUFF_RUN_MIN) && (r <= STUFF_RUN_MAX);
  endfunction

endpackage

// File: rtl/hs_nrzi_enc.sv
// NRZI line encoder: a stream 0 toggles the line, a 1 holds it; the line rests at 1.
// Built into hs_bitstuff_tx only when HS_BITSTUFF_NRZI_EN is defined.
module hs_nrzi_enc (
  input  logic clk,
  input  logic rst_n,
  input  logic in_bit,
  input  logic in_valid,
  output logic line
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= 1'b1;
    end else if (!in_valid) begin
      line <= 1'b1;
    end else if (!in_bit) begin
      line <= ~line;
    end
  end

endmodule

// File: rtl/hs_bitstuff_tx.sv
// Parallel-to-serial HS transmitter with zero-bit stuffing after STUFF_RUN consecutive ones.
// Optional NRZI line coding selected by the HS_BITSTUFF_NRZI_EN macro.
module hs_bitstuff_tx
  import hs_utmi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STUFF_RUN = STUFF_RUN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              stuff_ind,
  output logic              hold_full,
  output state_t            dbg_state
);

  // Handshake: a word is taken on a rising edge where tx_valid and tx_ready
  // are both high; tx_ready is simply "holding register empty".

  localparam int CNT_W = $clog2(STUFF_RUN + 1);
  localparam int REM_W = $clog2(DATA_W + 1);

  state_t              state_q;
  state_t              state_nxt;
  logic [DATA_W-1:0]   hold_q;
  logic                hold_full_q;
  logic [DATA_W-1:0]   sh_q;
  logic [REM_W-1:0]    rem_q;
  logic [CNT_W-1:0]    ones_q;
  logic                bit_valid_q;
  logic                stuff_ind_q;

  logic last_bit;
  logic run_hit;
  logic sh_empty;
  logic load_sh;
  logic shift_en;
  logic emit_data;
  logic emit_stuff;
  logic clr_ones;
  logic line_bit;
  logic line_valid;

  assign last_bit = (rem_q == REM_W'(1));
  assign sh_empty = (rem_q == '0);
  // The bit now leaving the shifter completes the run when it is a one.
  assign run_hit  = sh_q[0] && (ones_q == CNT_W'(STUFF_RUN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (run_hit) begin
          state_nxt = ST_STUFF;
        end else if (last_bit && !hold_full_q) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_STUFF: begin
        if (!sh_empty || hold_full_q) begin
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_sh    = 1'b0;
    shift_en   = 1'b0;
    emit_data  = 1'b0;
    emit_stuff = 1'b0;
    clr_ones   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_sh  = hold_full_q;
        clr_ones = 1'b1;
      end
      ST_SHIFT: begin
        emit_data = 1'b1;
        shift_en  = 1'b1;
        load_sh   = last_bit && hold_full_q;
      end
      ST_STUFF: begin
        emit_stuff = 1'b1;
        clr_ones   = 1'b1;
        // A run that ended on a word's last bit left the shifter empty.
        load_sh    = sh_empty && hold_full_q;
      end
      ST_DRAIN: begin
        clr_ones = 1'b1;
      end
      default: begin
        clr_ones = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (load_sh) hold_full_q <= 1'b0;
      if (tx_valid && !hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      rem_q <= '0;
    end else if (load_sh) begin
      sh_q  <= hold_q;
      rem_q <= REM_W'(DATA_W);
    end else if (shift_en) begin
      sh_q  <= sh_q >> 1;
      rem_q <= rem_q - REM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
    end else if (clr_ones) begin
      ones_q <= '0;
    end else if (emit_data) begin
      ones_q <= sh_q[0] ? ones_q + CNT_W'(1) : '0;
    end
  end

  assign line_bit   = emit_data & sh_q[0];
  assign line_valid = emit_data | emit_stuff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_valid_q <= 1'b0;
      stuff_ind_q <= 1'b0;
    end else begin
      bit_valid_q <= line_valid;
      stuff_ind_q <= emit_stuff;
    end
  end

`ifdef HS_BITSTUFF_NRZI_EN
  hs_nrzi_enc u_nrzi (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_bit   (line_bit),
    .in_valid (line_valid),
    .line     (bit_out)
  );
`else
  logic bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= line_bit;
    end
  end

  assign bit_out = bit_q;
`endif

  assign bit_valid = bit_valid_q;
  assign stuff_ind = stuff_ind_q;
  assign hold_full = hold_full_q;
  assign tx_ready  = ~hold_full_q;
  assign dbg_state = state_q;

endmodule
